// File: rtl/s2p_frame_pkg.sv
// Shared definitions for the s2p_frame serial/parallel shifter.
// Contents: mode codes, frame-state codes and the beat-counter width helper.
package s2p_frame_pkg;

  // Mode codes. Code 2'b11 used to fall through to LOAD; it now selects FRAME.
  typedef enum logic [1:0] {
    MODE_PUSH  = 2'b00,
    MODE_CYCLE = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_FRAME = 2'b11
  } mode_e;

  // Frame collection state.
  typedef enum logic {
    S2P_SHIFT = 1'b0,
    S2P_STALL = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_LANE  = 1;

  // Width of the beat counter: max(1, clog2(beats)).
  function automatic int unsigned cnt_width(input int unsigned beats);
    int unsigned w;
    w = 1;
    while ((32'(1) << w) < beats) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/s2p_frame_if.sv
// Bus interfaces for s2p_frame.
//   s2p_ser_if : serial beat side  (s_in, s_valid from the link; s_ready back).
//   s2p_par_if : parallel frame side (p_out, p_valid [, p_par] to the consumer; p_ready back).
// Optional: `S2P_FRAME_PARITY_EN adds p_par to s2p_par_if.
interface s2p_ser_if #(
  parameter int unsigned LANE = 1
);
  logic [LANE-1:0] s_in;
  logic            s_valid;
  logic            s_ready;

  modport master (output s_in, output s_valid, input s_ready);
  modport slave  (input s_in, input s_valid, output s_ready);
endinterface

interface s2p_par_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] p_out;
  logic             p_valid;
  logic             p_ready;
`ifdef S2P_FRAME_PARITY_EN
  logic             p_par;

  modport master (output p_out, output p_valid, output p_par, input p_ready);
  modport slave  (input p_out, input p_valid, input p_par, output p_ready);
`else
  modport master (output p_out, output p_valid, input p_ready);
  modport slave  (input p_out, input p_valid, output p_ready);
`endif
endinterface

// File: rtl/s2p_frame_out_reg.sv
// s2p_out_reg: holding register for completed frames (p_out/p_valid).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load, data : capture data as a new frame (wins over a consume on the same edge)
//   p_ready    : consumer accepts the current frame
//   p_out, p_valid : registered frame and its valid flag
//   p_par      : even parity of the captured word (only with `S2P_FRAME_PARITY_EN)
module s2p_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             p_ready,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid
`ifdef S2P_FRAME_PARITY_EN
  ,
  output logic             p_par
`endif
);

  // Load and consume together keeps p_valid high with the new word (no bubble).
  always_ff @(posedge clk) begin
    if (reset) begin
      p_out   <= '0;
      p_valid <= 1'b0;
`ifdef S2P_FRAME_PARITY_EN
      p_par   <= 1'b0;
`endif
    end else if (load) begin
      p_out   <= data;
      p_valid <= 1'b1;
`ifdef S2P_FRAME_PARITY_EN
      p_par   <= ^data;
`endif
    end else if (p_valid && p_ready) begin
      p_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/s2p_frame.sv
// s2p_frame: LANE-bit serial/parallel shifter with PUSH, CYCLE, LOAD and FRAME modes.
// FRAME collects WIDTH/LANE serial beats and hands each completed word to a
// downstream consumer over valid/ready, back-pressuring the serial side when
// the output register is still full.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   enb        : shift-register enable (0 holds q, s_out, cnt and state)
//   modo       : mode (mode_e)
//   dir        : 0 = shift toward MSB, 1 = shift toward LSB
//   d          : parallel load data
//   ser        : serial beat interface (slave)
//   par        : completed-frame interface (master)
//   q, s_out, cnt : register contents, bits shifted out, beats collected
// Optional: `S2P_FRAME_PARITY_EN adds par.p_par (even parity of p_out).
module s2p_frame
  import s2p_frame_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned LANE  = DEF_LANE,
  localparam int unsigned BEATS = WIDTH / LANE,
  localparam int unsigned CW    = cnt_width(BEATS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic             dir,
  input  logic [WIDTH-1:0] d,
  s2p_ser_if.slave         ser,
  s2p_par_if.master        par,
  output logic [WIDTH-1:0] q,
  output logic [LANE-1:0]  s_out,
  output logic [CW-1:0]    cnt
);

  state_e               state, state_nxt;
  logic [WIDTH-1:0]     q_nxt;
  logic [LANE-1:0]      s_out_nxt;
  logic [CW-1:0]        cnt_nxt;

  logic [WIDTH+LANE-1:0] cat_up, cat_dn;
  logic [2*WIDTH-1:0]    dbl;
  logic [WIDTH-1:0]      shift_q, rot_q;
  logic [LANE-1:0]       shift_out;

  logic                 frame_mode, beat, last_beat;
  logic                 out_load;
  logic [WIDTH-1:0]     out_data;

  // Shift/rotate datapath; the widened concatenations keep LANE==WIDTH legal.
  always_comb begin
    cat_up = {q, ser.s_in};
    cat_dn = {ser.s_in, q};
    dbl    = {q, q};
    if (dir) begin
      shift_q   = cat_dn[WIDTH+LANE-1:LANE];
      shift_out = cat_dn[LANE-1:0];
      rot_q     = dbl[LANE +: WIDTH];
    end else begin
      shift_q   = cat_up[WIDTH-1:0];
      shift_out = cat_up[WIDTH+LANE-1:WIDTH];
      rot_q     = dbl[2*WIDTH-LANE-1 -: WIDTH];
    end
  end

  // Beat acceptance handshake.
  assign frame_mode  = (modo == MODE_FRAME);
  assign ser.s_ready = enb & frame_mode & (state == S2P_SHIFT);
  assign beat        = ser.s_ready & ser.s_valid;
  assign last_beat   = beat & (cnt == CW'(BEATS - 1));

  // State register and shift-register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S2P_SHIFT;
      q     <= '0;
      s_out <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      s_out <= s_out_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and frame hand-off decode.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    s_out_nxt = s_out;
    cnt_nxt   = cnt;
    out_load  = 1'b0;
    out_data  = q;

    if (enb) begin
      case (mode_e'(modo))
        MODE_PUSH: begin
          q_nxt     = shift_q;
          s_out_nxt = shift_out;
          cnt_nxt   = '0;
          state_nxt = S2P_SHIFT;
        end
        MODE_CYCLE: begin
          q_nxt     = rot_q;
          s_out_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = S2P_SHIFT;
        end
        MODE_LOAD: begin
          q_nxt     = d;
          s_out_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = S2P_SHIFT;
        end
        MODE_FRAME: begin
          if (state == S2P_SHIFT) begin
            if (beat) begin
              q_nxt     = shift_q;
              s_out_nxt = shift_out;
              if (last_beat) begin
                cnt_nxt = '0;
                // Hand off now if the output slot is free or being drained,
                // otherwise park the frame in q until the consumer is ready.
                if (!par.p_valid || par.p_ready) begin
                  out_load = 1'b1;
                  out_data = shift_q;
                end else begin
                  state_nxt = S2P_STALL;
                end
              end else begin
                cnt_nxt = cnt + CW'(1);
              end
            end
          end else if (par.p_ready) begin
            out_load  = 1'b1;
            out_data  = q;
            state_nxt = S2P_SHIFT;
          end
        end
        default: begin
          state_nxt = S2P_SHIFT;
        end
      endcase
    end else if (state == S2P_STALL && par.p_ready) begin
      // A parked frame still transfers while the shifter is disabled.
      out_load  = 1'b1;
      out_data  = q;
      state_nxt = S2P_SHIFT;
    end
  end

  s2p_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (out_load),
    .data    (out_data),
    .p_ready (par.p_ready),
    .p_out   (par.p_out),
    .p_valid (par.p_valid)
`ifdef S2P_FRAME_PARITY_EN
    ,
    .p_par   (par.p_par)
`endif
  );

endmodule

// File: doc/s2p_frame.md
Name: s2p_frame

Overview:
- Parametrised successor to the single-bit conditional serial/parallel shifter.
- Shifts LANE bits per step and keeps the PUSH, CYCLE and LOAD modes.
- Adds a FRAME mode: counts serial beats and hands each completed WIDTH-bit word to a downstream consumer over a valid/ready handshake, with backpressure on the serial side.
- Sits between a serial link receiver and a parallel datapath.

Parameters:
- WIDTH, 8: register/word width in bits.
- LANE, 1: bits shifted per step. Must divide WIDTH; WIDTH/LANE >= 1.
- BEATS, WIDTH/LANE: beats per frame (derived; not overridden).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENB  in  1  shift-register enable. 0 holds Q, S_OUT and CNT.
- MODO  in  2  mode: `PUSH, `CYCLE, `LOAD, `FRAME.
- DIR  in  1  0 = shift toward MSB (entry at LSB); 1 = shift toward LSB (entry at MSB).
- D  in  WIDTH  parallel load data.
- S_IN  in  LANE  serial input lane.
- S_VALID  in  1  S_IN valid (FRAME mode only).
- S_READY  out  1  beat accepted when S_VALID & S_READY.
- Q  out  WIDTH  shift register contents.
- S_OUT  out  LANE  bits shifted out.
- CNT  out  max(1,$clog2(BEATS))  beats collected in the current frame.
- P_OUT  out  WIDTH  completed frame.
- P_VALID  out  1  P_OUT holds an unconsumed frame.
- P_READY  in  1  consumer accepts P_OUT.

Behaviour:
- Reset (RESET=1 at an edge; overrides everything):
  - Q=0, S_OUT=0, CNT=0, P_OUT=0, P_VALID=0, state=SHIFT.
- Modes (ENB=1):
  - PUSH: shift by LANE in DIR using S_IN; S_OUT <= the LANE bits leaving. S_VALID is ignored.
  - CYCLE: rotate by LANE in DIR; S_OUT <= 0.
  - LOAD: Q <= D; S_OUT <= 0.
  - Any mode other than FRAME clears CNT and forces state=SHIFT. Any frame in progress is discarded.
- FRAME mode, state SHIFT:
  - S_READY = ENB & (MODO==`FRAME) & (state==SHIFT). Combinational.
  - On an accepted beat, Q shifts as in PUSH and S_OUT gets the leaving bits.
  - If CNT < BEATS-1, CNT increments.
  - On the final beat (CNT==BEATS-1), CNT <= 0:
    - if ~P_VALID | P_READY: P_OUT <= new Q value and P_VALID <= 1 on the same edge. P_VALID is visible 1 cycle after the final beat is presented.
    - else: state <= STALL, and the frame is held in Q.
  - No accepted beat: Q, CNT and S_OUT hold.
- State STALL:
  - S_READY=0.
  - When P_READY: P_OUT <= Q, P_VALID stays 1, state <= SHIFT. A new beat may be accepted the following cycle.
- Output handshake (independent of ENB and MODO):
  - P_VALID & P_READY with no new frame loading: P_VALID <= 0.
  - Consume and load on the same edge: P_VALID stays 1 with the new data (back-to-back, no bubble).
  - P_OUT is stable while P_VALID & ~P_READY.
- ENB=0: Q, S_OUT, CNT and state hold; S_READY=0. The P_OUT drain still occurs. A STALL transfer on P_READY still completes.
- LANE==WIDTH: every beat is a complete frame; CNT stays 0.
- Bit order: DIR=0 puts the first beat at the MSB end (MSB-first). DIR=1 puts the first beat at the LSB end.
- A DIR change mid-frame is legal; the data is whatever the shifts produce.

Optional Feature:
- Macro S2P_FRAME_PARITY_EN.
- Defined: extra output P_PAR (1 bit), registered alongside P_OUT and equal to even parity (^) of the loaded word. Reset value 0.
- Undefined: no P_PAR port and no parity logic.

Decomposition:
- definitions.v (shared):
  - `PUSH 2'b00, `CYCLE 2'b01, `LOAD 2'b10, `FRAME 2'b11. These replace the old default-to-LOAD use of code 11.
  - State codes `S2P_SHIFT 1'b0, `S2P_STALL 1'b1.
- One sub-module, s2p_out_reg: the P_OUT/P_VALID holding register with its load/consume logic (and P_PAR when the macro is enabled).

Test Plan:
- Frame, DIR=0 (WIDTH=8, LANE=2, FRAME, P_READY=1): beats 11,10,01,00 on consecutive cycles -> P_OUT=8'hE4, P_VALID=1 one cycle after the 4th beat; CNT runs 0,1,2,3,0.
- Frame, DIR=1: same beats with DIR=1 -> P_OUT=8'h1B.
- Backpressure: P_READY=0, frames 8'hE4 then 8'h1B -> after the second final beat, state=STALL, S_READY=0, P_OUT=8'hE4. Raise P_READY for 1 cycle -> P_OUT=8'h1B, P_VALID=1, S_READY=1 the next cycle.
- Mode abort: 2 FRAME beats, then LOAD with D=8'hA5 -> Q=8'hA5, CNT=0; 4 further FRAME beats produce exactly 1 frame.
- Reset: RESET=1 mid-frame while in STALL -> next cycle all outputs 0, S_READY=1 (ENB=1, FRAME).
- PUSH/CYCLE (LANE=2): Q=8'hC3 PUSH DIR=0 S_IN=01 -> Q=8'h0D, S_OUT=11. CYCLE DIR=1 -> Q=8'h43.
